// File: rtl/calc_op_sequencer_pkg.sv
// Shared definitions for the calculator sequencer: state codes, opcodes, control word.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package calc_op_sequencer_pkg;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_A    = 3'd1,
        ST_LOAD_OP   = 3'd2,
        ST_LOAD_B    = 3'd3,
        ST_START_ALU = 3'd4,
        ST_WAIT_ALU  = 3'd5,
        ST_SHOW      = 3'd6,
        ST_ERROR     = 3'd7
    } state_t;

    // Opcode values as seen on the Op switches
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Control word driven to the datapath; *_n fields are active-low
    typedef struct packed {
        logic reset_n;
        logic a_load_n;
        logic op_load_n;
        logic b_load_n;
        logic r_load_n;
        logic ou_load;
        logic iu_au;
        logic alu_start;
        logic err;
        logic busy;
    } ctrl_t;

    // Moore output decode: control word belonging to each state
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '{reset_n: 1'b1, a_load_n: 1'b1, op_load_n: 1'b1, b_load_n: 1'b1,
              r_load_n: 1'b1, ou_load: 1'b0, iu_au: 1'b0, alu_start: 1'b0,
              err: 1'b0, busy: 1'b0};
        case (s)
            ST_IDLE: begin
                c.reset_n = 1'b0;
                c.ou_load = 1'b1;
            end
            ST_LOAD_A:    c.a_load_n  = 1'b0;
            ST_LOAD_OP:   c.op_load_n = 1'b0;
            ST_LOAD_B:    c.b_load_n  = 1'b0;
            ST_START_ALU: begin
                c.alu_start = 1'b1;
                c.busy      = 1'b1;
            end
            ST_WAIT_ALU: begin
                c.iu_au = 1'b1;
                c.busy  = 1'b1;
            end
            ST_SHOW: begin
                c.r_load_n = 1'b0;
                c.iu_au    = 1'b1;
            end
            ST_ERROR: begin
                c.iu_au = 1'b1;
                c.err   = 1'b1;
            end
            default: c.reset_n = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/calc_op_sequencer_enter_press_detect.sv
// Synchronises an active-low pushbutton and emits a one-cycle pulse per press (falling edge).
// Latency: pulse appears SYNC_STAGES+1 cycles after the button falls; held button gives one pulse.
// Backpressure: none; pulses are fire-and-forget, the consumer drops any it cannot use.
module enter_press_detect
    import calc_op_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic CLR,
    input  logic btn_n,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    // primed[SYNC_STAGES] is set once both sync output and hist hold real button samples,
    // so a button already held low when CLR releases is not mistaken for a new press
    logic [SYNC_STAGES:0]   primed;

    // Synchroniser chain, edge history and one-shot pulse register
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            sync   <= '1;
            hist   <= 1'b1;
            primed <= '0;
            press  <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], btn_n};
            hist   <= sync[SYNC_STAGES-1];
            primed <= {primed[SYNC_STAGES-1:0], 1'b1};
            press  <= primed[SYNC_STAGES] & hist & ~sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator sequencer: steps A -> opcode -> B entry on Enter, runs the ALU with a watchdog, traps divide-by-zero.
// Latency: state advances one cycle after the internal press pulse; outputs are registered with the state.
// Backpressure: presses arriving while the ALU is busy are dropped; ALU_Done outside WAIT_ALU is ignored.
module calc_op_sequencer
    import calc_op_sequencer_pkg::*;
#(
    parameter int         SYNC_STAGES    = 2,
    parameter int         TIMEOUT_CYCLES = 32,
    parameter logic [1:0] DIV_OPCODE     = OP_DIV
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       Enter,
    input  logic [1:0] Op,
    input  logic       B_Zero,
    input  logic       ALU_Done,
    output logic       A_Load,
    output logic       OP_Load,
    output logic       B_Load,
    output logic       R_Load,
    output logic       ALU_Start,
    output logic       OU_Load,
    output logic       RESET,
    output logic       IU_AU,
    output logic       ERR,
    output logic       Busy
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           nxt;
    ctrl_t            ctrl;
    logic [1:0]       opreg;
    logic [CNT_W-1:0] wd_cnt;
    logic             press;

    enter_press_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_enter (
        .CLK  (CLK),
        .CLR  (CLR),
        .btn_n(Enter),
        .press(press)
    );

    // Next-state selection; press pulses are only consumed in the operator-facing states
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:      if (press) nxt = ST_LOAD_A;
            ST_LOAD_A:    if (press) nxt = ST_LOAD_OP;
            ST_LOAD_OP:   if (press) nxt = ST_LOAD_B;
            ST_LOAD_B: begin
                if (press) begin
                    if (opreg == DIV_OPCODE && B_Zero) nxt = ST_ERROR;
                    else                               nxt = ST_START_ALU;
                end
            end
            ST_START_ALU: nxt = ST_WAIT_ALU;
            ST_WAIT_ALU: begin
                // Done on the final watchdog cycle still counts as success
                if (ALU_Done)                nxt = ST_SHOW;
                else if (wd_cnt == WD_LAST)  nxt = ST_ERROR;
            end
            ST_SHOW:      if (press) nxt = ST_LOAD_A;
            ST_ERROR:     if (press) nxt = ST_IDLE;
            default:      nxt = ST_IDLE;
        endcase
    end

    // State, registered control word, latched opcode and ALU watchdog
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state  <= ST_IDLE;
            ctrl   <= decode_ctrl(ST_IDLE);
            opreg  <= 2'b00;
            wd_cnt <= '0;
        end else begin
            state <= nxt;
            ctrl  <= decode_ctrl(nxt);
            // Divide check must use the opcode the datapath latched, not the live switches
            if (state == ST_LOAD_OP && press) opreg <= Op;
            if (state == ST_START_ALU)
                wd_cnt <= '0;
            else if (state == ST_WAIT_ALU && wd_cnt != WD_LAST)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign RESET     = ctrl.reset_n;
    assign A_Load    = ctrl.a_load_n;
    assign OP_Load   = ctrl.op_load_n;
    assign B_Load    = ctrl.b_load_n;
    assign R_Load    = ctrl.r_load_n;
    assign OU_Load   = ctrl.ou_load;
    assign IU_AU     = ctrl.iu_au;
    assign ALU_Start = ctrl.alu_start;
    assign ERR       = ctrl.err;
    assign Busy      = ctrl.busy;

endmodule
